// File: rtl/rr_arb4_pkg.sv
// rtl/rr_arb4_pkg.sv - shared types and constants for the 4-way round-robin arbiter
//
// Purpose : state enum, requester count, default tenure limit and a one-hot
//           helper used by rr_arb4 and rr_pick4.
// Ports   : none (package).
package rr_arb4_pkg;

  localparam int NUM_REQ          = 4;
  localparam int HOLD_MAX_DEFAULT = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // One-hot vector selecting a single requester index.
  function automatic logic [NUM_REQ-1:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - combinational rotating-priority search over four requests
//
// Purpose : finds the first set request starting at ptr and wrapping
//           (ptr, ptr+1, ptr+2, ptr+3 mod 4), ignoring bits set in mask.
// Ports   : req   [3:0] in  - request lines
//           ptr   [1:0] in  - index searched first
//           mask  [3:0] in  - requesters excluded from the search (current owner)
//           found       out - at least one unmasked request is set
//           idx   [1:0] out - index of the selected requester (ptr when !found)
module rr_pick4
  import rr_arb4_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         ptr,
  input  logic [NUM_REQ-1:0] mask,
  output logic               found,
  output logic [1:0]         idx
);

  logic [NUM_REQ-1:0] cand;
  logic [1:0]         pos;

  always_comb begin
    cand  = req & ~mask;
    found = 1'b0;
    idx   = ptr;
    pos   = ptr;
    // Walk from the farthest offset back to ptr so the closest hit wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pos = ptr + k[1:0];
      if (cand[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/rr_arb4.sv
// rtl/rr_arb4.sv - 4-requester round-robin arbiter with registered grant index/enable
//
// Purpose : grants one of four requesters at a time; the owner keeps the grant
//           while its request stays high, and on release priority rotates to
//           the requester after it. Handoff to a waiting requester has no gap.
//           Optional tenure limit selected by macro RR_ARB4_TIMEOUT_EN: after
//           HOLD_MAX cycles of tenure the grant is rotated if anyone else waits.
// Params  : HOLD_MAX - maximum grant tenure in cycles with the limit compiled in (2..255)
// Ports   : clk         in  - single clock, rising edge
//           rst_n       in  - asynchronous active-low reset
//           req   [3:0] in  - request lines, bit i = requester i
//           W     [1:0] out - granted index (decoder select), holds when idle
//           En          out - grant valid (decoder enable)
module rr_arb4
  import rr_arb4_pkg::*;
#(
  parameter int HOLD_MAX = HOLD_MAX_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [1:0]         W,
  output logic               En
);

  if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_hold_max_check
    $error("rr_arb4: HOLD_MAX must be in 2..255");
  end

  state_e     state_q, state_d;
  logic [1:0] w_q, w_d;
  logic [1:0] ptr_q, ptr_d;

  logic [1:0]         pick_ptr;
  logic [NUM_REQ-1:0] pick_mask;
  logic               pick_found;
  logic [1:0]         pick_idx;

  logic rotate;
  logic new_grant;
  logic timeout;

  rr_pick4 u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .mask  (pick_mask),
    .found (pick_found),
    .idx   (pick_idx)
  );

`ifdef RR_ARB4_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  logic [7:0] cnt_q, cnt_d;

  // In GRANT the pick is masked to the owner, so pick_found means someone else waits.
  always_comb begin
    timeout = (state_q == GRANT) && (cnt_q == HOLD_LAST) && pick_found;
  end

  // Clears on every new grant, counts GRANT cycles and saturates at HOLD_MAX-1.
  always_comb begin
    cnt_d = cnt_q;
    if (new_grant) begin
      cnt_d = 8'd0;
    end else if (state_q == GRANT && cnt_q != HOLD_LAST) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  always_comb begin
    timeout = 1'b0;
  end
`endif

  always_comb begin
    state_d   = state_q;
    w_d       = w_q;
    ptr_d     = ptr_q;
    pick_ptr  = ptr_q;
    pick_mask = '0;
    rotate    = 1'b0;
    new_grant = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          w_d       = pick_idx;
          state_d   = GRANT;
          new_grant = 1'b1;
        end
      end

      GRANT: begin
        // Search for a successor starting after the owner, owner excluded,
        // so a requester that re-raises immediately goes to the back.
        pick_ptr  = w_q + 2'd1;
        pick_mask = onehot4(w_q);
        rotate    = !req[w_q] || timeout;
        if (rotate) begin
          ptr_d = w_q + 2'd1;
          if (pick_found) begin
            w_d       = pick_idx;
            new_grant = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      w_q     <= 2'b00;
      ptr_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      ptr_q   <= ptr_d;
    end
  end

  assign W  = w_q;
  assign En = (state_q == GRANT);

endmodule

// File: tb/tb_rr_arb4.sv
// tb/tb_rr_arb4.sv - scoreboard bench for rr_arb4 against a behavioural round-robin model
module tb_rr_arb4;

`ifdef RR_ARB4_TIMEOUT_EN
  localparam int HM = 4;
  localparam bit TO = 1'b1;
`else
  localparam int HM = 8;
  localparam bit TO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [1:0] W;
  logic       En;

  always #5 clk = ~clk;

  rr_arb4 #(.HOLD_MAX(HM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .W     (W),
    .En    (En)
  );

  typedef struct {
    logic [1:0] w;
    logic       en;
  } exp_t;

  exp_t exp_q[$];
  int   glog[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: who owns the channel, where the next search starts,
  // how long the owner has held it.
  int m_w, m_ptr, m_ten;
  bit m_active;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int search(input logic [3:0] r, input int start, input int skip);
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (start + k) % 4;
      if (i != skip && r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_w = 0; m_ptr = 0; m_ten = 0; m_active = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] r);
    int  nxt;
    bit  others;
    if (!m_active) begin
      nxt = search(r, m_ptr, -1);
      if (nxt >= 0) begin
        m_w = nxt; m_active = 1'b1; m_ten = 0;
      end
    end else begin
      others = (r & ~(4'b0001 << m_w)) != 4'b0000;
      if (!r[m_w] || (TO && m_ten == HM - 1 && others)) begin
        m_ptr = (m_w + 1) % 4;
        nxt = search(r, m_ptr, m_w);
        if (nxt >= 0) begin
          m_w = nxt; m_ten = 0;
        end else begin
          m_active = 1'b0;
        end
      end else if (m_ten < HM - 1) begin
        m_ten++;
      end
    end
  endtask

  // Present r for the coming edge and record what the model says follows it.
  task automatic apply(input logic [3:0] r);
    exp_t e;
    req = r;
    model_step(r);
    e.w  = 2'(m_w);
    e.en = m_active;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [3:0] r);
    @(negedge clk);
    apply(r);
  endtask

  task automatic expect_now(input string nm, input int w, input int en);
    @(posedge clk);
    #1;
    check({nm, "_W"}, W, w);
    check({nm, "_En"}, En, en);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 4'b0000;
    model_reset();
    #1;
    check("rst_W", W, 0);
    check("rst_En", En, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: compares every output edge that has an expectation queued.
  logic       prev_en = 1'b0;
  logic [1:0] prev_w  = 2'b00;
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_W", W, e.w);
        check("sb_En", En, e.en);
      end
      if (En && (!prev_en || W != prev_w)) glog.push_back(int'(W));
      prev_en = En;
      prev_w  = W;
    end
  end

  initial begin
    logic [3:0] v;
    int         order[5];
    order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;

    rst_n = 1'b1;
    req   = 4'b1111;
    model_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold_W", W, 0);
    check("reset_hold_En", En, 0);

    // First edge after release grants requester 0.
    @(negedge clk);
    rst_n = 1'b1;
    apply(4'b1111);
    expect_now("first_grant", 0, 1);
    drive(4'b0000);
    drive(4'b0000);

    // Single request, then release to IDLE with W holding.
    drive(4'b0100);
    expect_now("single_grant", 2, 1);
    drive(4'b0000);
    expect_now("single_release", 2, 0);

    // Owner 3, requester 0 waiting; drop of req[3] wraps to 0 with no gap.
    drive(4'b1000);
    expect_now("wrap_own3", 3, 1);
    drive(4'b1001);
    expect_now("wrap_hold3", 3, 1);
    drive(4'b0001);
    expect_now("wrap_handoff", 0, 1);
    drive(4'b0000);
    drive(4'b0000);

    // Fairness from reset: everyone requests, each owner drops for one cycle.
    do_reset();
    glog.delete();
    drive(4'b1111);
    for (int r = 0; r < 4; r++) begin
      repeat (3) drive(4'b1111);
      v = 4'b1111;
      v[m_w[1:0]] = 1'b0;
      drive(v);
    end
    drive(4'b0000);
    drive(4'b0000);
    @(posedge clk);
    #2;
    check("fair_count", glog.size(), 5);
    for (int i = 0; i < 5 && i < glog.size(); i++) check("fair_order", glog[i], order[i]);

    // Asynchronous reset between edges while granted.
    drive(4'b0010);
    expect_now("async_pre", 1, 1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_En", En, 0);
    check("async_W", W, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    apply(4'b1110);
    expect_now("post_reset_grant", 1, 1);
    drive(4'b0000);
    drive(4'b0000);

`ifdef RR_ARB4_TIMEOUT_EN
    // Tenure limit: owner 0 keeps requesting but 1 waits.
    do_reset();
    drive(4'b0011);
    expect_now("to_grant0", 0, 1);
    repeat (3) drive(4'b0011);
    expect_now("to_hold4", 0, 1);
    drive(4'b0011);
    expect_now("to_rotate", 1, 1);
    drive(4'b0000);
    drive(4'b0000);
    // Alone at timeout: grant continues, counter saturates, rotates once 1 shows up.
    repeat (10) drive(4'b0001);
    expect_now("to_alone", 0, 1);
    drive(4'b0011);
    expect_now("to_sat_rotate", 1, 1);
    drive(4'b0000);
    drive(4'b0000);
`endif

    // Randomized traffic; the owner's bit is usually kept high to build long tenures.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      v = 4'($urandom_range(0, 15));
      if (m_active && $urandom_range(0, 3) != 0) v[m_w[1:0]] = 1'b1;
      drive(v);
    end
    drive(4'b0000);
    drive(4'b0000);

    for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(posedge clk);
    #2;
    check("drain_left", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
